// File: rtl/draw_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : draw_pkg
//  Description : Shared types and screen constants for the draw scheduler.
//                sched_state_t  - scheduler FSM state encoding
//                SCREEN_W/H     - VGA adapter resolution in pixels
//  Revision    : 1.0  initial release
// ============================================================================
package draw_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FILL     = 3'd1,
        FILL_REL = 3'd2,
        DRAW     = 3'd3,
        DRAW_REL = 3'd4,
        DONE     = 3'd5
    } sched_state_t;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

endpackage
`default_nettype wire

// File: rtl/phase_timer.sv
`default_nettype none
// ============================================================================
//  Module      : phase_timer
//  Description : Saturating per-phase cycle counter. Cleared by clr, raises
//                expired once the count reaches TIMEOUT_CYCLES-1 and holds
//                there until the next clear.
//  Ports       : clk      in  clock, rising edge
//                rst_n    in  asynchronous reset, active-low
//                clr      in  restart the count from zero
//                expired  out count has reached TIMEOUT_CYCLES-1
//  Revision    : 1.0  initial release
// ============================================================================
module phase_timer #(
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic expired
);

    localparam int                c_cnt_w = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(TIMEOUT_CYCLES - 1);

    logic [c_cnt_w-1:0] r_cnt;

    // Saturate at the terminal count so a stalled phase keeps expired high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (r_cnt != c_last) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expired = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/draw_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : draw_scheduler
//  Description : Sequences the fillscreen engine (clear to black) and then the
//                circle engine, owning the start/done handshake to each engine
//                and to the top level, and muxing the active engine's plot
//                stream onto the single VGA adapter plot port (1-cycle
//                registered latency).
//  Ports       : clk, rst_n                  clock / async active-low reset
//                start, done                 top-level handshake
//                err                         sticky phase-timeout flag
//                f_start, f_done, f_*        fillscreen engine handshake/stream
//                c_start, c_done, c_*        circle engine handshake/stream
//                vga_x/vga_y/vga_colour/vga_plot  to VGA adapter
//  Config      : DRAW_SCHED_TIMEOUT_EN - adds a per-phase timeout of
//                TIMEOUT_CYCLES cycles and drives err; without it err is 0
//                and each phase waits indefinitely.
//  Revision    : 1.0  initial release
// ============================================================================
module draw_scheduler
    import draw_pkg::*;
#(
    parameter int X_W            = 8,
    parameter int Y_W            = 7,
    parameter int C_W            = 3,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    output logic           done,
    output logic           err,
    output logic           f_start,
    input  logic           f_done,
    input  logic [X_W-1:0] f_x,
    input  logic [Y_W-1:0] f_y,
    input  logic [C_W-1:0] f_colour,
    input  logic           f_plot,
    output logic           c_start,
    input  logic           c_done,
    input  logic [X_W-1:0] c_x,
    input  logic [Y_W-1:0] c_y,
    input  logic [C_W-1:0] c_colour,
    input  logic           c_plot,
    output logic [X_W-1:0] vga_x,
    output logic [Y_W-1:0] vga_y,
    output logic [C_W-1:0] vga_colour,
    output logic           vga_plot
);

    sched_state_t   r_state;
    sched_state_t   w_next_state;
    logic           w_expired;
    logic           w_timeout_exit;

    logic [X_W-1:0] r_vga_x;
    logic [Y_W-1:0] r_vga_y;
    logic [C_W-1:0] r_vga_colour;
    logic           r_vga_plot;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Each engine phase is followed by a release state
    // that waits for the engine's done to drop, so a done still high from
    // the previous phase can never be mistaken for the next handshake.
    // A genuine done wins over a coincident timer expiry.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state   = r_state;
        w_timeout_exit = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next_state = FILL;
            end
            FILL: begin
                if (f_done) begin
                    w_next_state = FILL_REL;
                end else if (w_expired) begin
                    w_next_state   = FILL_REL;
                    w_timeout_exit = 1'b1;
                end
            end
            FILL_REL: begin
                if (!f_done) begin
                    w_next_state = DRAW;
                end else if (w_expired) begin
                    w_next_state   = DRAW;
                    w_timeout_exit = 1'b1;
                end
            end
            DRAW: begin
                if (c_done) begin
                    w_next_state = DRAW_REL;
                end else if (w_expired) begin
                    w_next_state   = DRAW_REL;
                    w_timeout_exit = 1'b1;
                end
            end
            DRAW_REL: begin
                if (!c_done) begin
                    w_next_state = DONE;
                end else if (w_expired) begin
                    w_next_state   = DONE;
                    w_timeout_exit = 1'b1;
                end
            end
            DONE: begin
                if (!start) w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Handshake outputs decode the registered state only, so they reset
    // immediately and drop the cycle after the matching done is sampled.
    assign f_start = (r_state == FILL);
    assign c_start = (r_state == DRAW);
    assign done    = (r_state == DONE);

    // ------------------------------------------------------------------
    // Optional phase timeout
    // ------------------------------------------------------------------
`ifdef DRAW_SCHED_TIMEOUT_EN
    logic w_timer_clr;
    logic r_err;

    // Any state change restarts the count, so each phase gets a full budget.
    assign w_timer_clr = (w_next_state != r_state);

    phase_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_phase_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (w_timer_clr),
        .expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if ((r_state == IDLE) && (w_next_state == FILL)) begin
            r_err <= 1'b0;
        end else if (w_timeout_exit) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    logic w_unused_timeout;

    assign w_expired        = 1'b0;
    assign err              = 1'b0;
    assign w_unused_timeout = ^{TIMEOUT_CYCLES, w_timeout_exit};
`endif

    // ------------------------------------------------------------------
    // VGA plot mux: registered copy of the active engine's stream.
    // Outside the two engine phases only the strobe is forced low; the
    // coordinates and colour keep their last value.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vga_x      <= '0;
            r_vga_y      <= '0;
            r_vga_colour <= '0;
            r_vga_plot   <= 1'b0;
        end else begin
            case (r_state)
                FILL: begin
                    r_vga_x      <= f_x;
                    r_vga_y      <= f_y;
                    r_vga_colour <= f_colour;
                    r_vga_plot   <= f_plot;
                end
                DRAW: begin
                    r_vga_x      <= c_x;
                    r_vga_y      <= c_y;
                    r_vga_colour <= c_colour;
                    r_vga_plot   <= c_plot;
                end
                default: begin
                    r_vga_plot   <= 1'b0;
                end
            endcase
        end
    end

    assign vga_x      = r_vga_x;
    assign vga_y      = r_vga_y;
    assign vga_colour = r_vga_colour;
    assign vga_plot   = r_vga_plot;

endmodule
`default_nettype wire

// File: tb/tb_draw_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_draw_scheduler
//  Description : Self-checking bench for draw_scheduler. Directed vector
//                table plus hand-written sequences for reset, a full
//                fill/circle run with behavioural engines, and the optional
//                phase timeout (DRAW_SCHED_TIMEOUT_EN).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_draw_scheduler;
    import draw_pkg::*;

    localparam int X_W            = 8;
    localparam int Y_W            = 7;
    localparam int C_W            = 3;
    localparam int TIMEOUT_CYCLES = 64;
    localparam int OUT_W          = 5 + X_W + Y_W + C_W;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           done, err, f_start, c_start, vga_plot;
    logic [X_W-1:0] vga_x;
    logic [Y_W-1:0] vga_y;
    logic [C_W-1:0] vga_colour;

    // Engine ports: either directly driven by the bench or by the models.
    logic           use_model = 1'b0;
    logic           t_f_done = 1'b0, t_f_plot = 1'b0, t_c_done = 1'b0, t_c_plot = 1'b0;
    logic [X_W-1:0] t_f_x = '0, t_c_x = '0;
    logic [Y_W-1:0] t_f_y = '0, t_c_y = '0;
    logic [C_W-1:0] t_f_col = '0, t_c_col = '0;
    logic           m_f_done = 1'b0, m_f_plot = 1'b0, m_c_done = 1'b0, m_c_plot = 1'b0;
    logic [X_W-1:0] m_f_x = '0, m_c_x = '0;
    logic [Y_W-1:0] m_f_y = '0, m_c_y = '0;
    logic [C_W-1:0] m_f_col = '0, m_c_col = '0;

    logic           f_done, f_plot, c_done, c_plot;
    logic [X_W-1:0] f_x, c_x;
    logic [Y_W-1:0] f_y, c_y;
    logic [C_W-1:0] f_colour, c_colour;

    assign f_done   = use_model ? m_f_done : t_f_done;
    assign f_plot   = use_model ? m_f_plot : t_f_plot;
    assign f_x      = use_model ? m_f_x    : t_f_x;
    assign f_y      = use_model ? m_f_y    : t_f_y;
    assign f_colour = use_model ? m_f_col  : t_f_col;
    assign c_done   = use_model ? m_c_done : t_c_done;
    assign c_plot   = use_model ? m_c_plot : t_c_plot;
    assign c_x      = use_model ? m_c_x    : t_c_x;
    assign c_y      = use_model ? m_c_y    : t_c_y;
    assign c_colour = use_model ? m_c_col  : t_c_col;

    draw_scheduler #(
        .X_W            (X_W),
        .Y_W            (Y_W),
        .C_W            (C_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .done       (done),
        .err        (err),
        .f_start    (f_start),
        .f_done     (f_done),
        .f_x        (f_x),
        .f_y        (f_y),
        .f_colour   (f_colour),
        .f_plot     (f_plot),
        .c_start    (c_start),
        .c_done     (c_done),
        .c_x        (c_x),
        .c_y        (c_y),
        .c_colour   (c_colour),
        .c_plot     (c_plot),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    always #5 clk = ~clk;

    // Behavioural engines, updated on the falling edge: plot one pixel per
    // cycle while start is high, then hold done until start drops.
    int fill_cnt = 0;
    int circ_cnt = 0;

    always @(negedge clk) begin
        if (!f_start) begin
            m_f_plot = 1'b0;
            m_f_done = 1'b0;
            fill_cnt = 0;
        end else if (fill_cnt < SCREEN_W * SCREEN_H) begin
            m_f_plot = 1'b1;
            m_f_x    = X_W'(fill_cnt % SCREEN_W);
            m_f_y    = Y_W'(fill_cnt / SCREEN_W);
            m_f_col  = '0;
            fill_cnt = fill_cnt + 1;
        end else begin
            m_f_plot = 1'b0;
            m_f_done = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!c_start) begin
            m_c_plot = 1'b0;
            m_c_done = 1'b0;
            circ_cnt = 0;
        end else if (circ_cnt < 40) begin
            m_c_plot = 1'b1;
            m_c_x    = X_W'(10 + circ_cnt);
            m_c_y    = Y_W'(20 + circ_cnt);
            m_c_col  = 3'd2;
            circ_cnt = circ_cnt + 1;
        end else begin
            m_c_plot = 1'b0;
            m_c_done = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks = checks + 1;
        if (act !== req) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // {f_start, c_start, done, err, vga_plot, vga_x, vga_y, vga_colour}
    function automatic logic [OUT_W-1:0] outs();
        return {f_start, c_start, done, err, vga_plot, vga_x, vga_y, vga_colour};
    endfunction

    typedef struct {
        logic           start;
        logic           f_done;
        logic           f_plot;
        logic [X_W-1:0] f_x;
        logic [Y_W-1:0] f_y;
        logic [C_W-1:0] f_col;
        logic           c_done;
        logic           c_plot;
        logic [X_W-1:0] c_x;
        logic [Y_W-1:0] c_y;
        logic [C_W-1:0] c_col;
        logic [OUT_W-1:0] expv;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int st, input int fd, input int fp, input int fx,
                                input int fy, input int fc, input int cd, input int cp,
                                input int cx, input int cy, input int cc,
                                input int efs, input int ecs, input int ed, input int ep,
                                input int ex, input int ey, input int ec);
        vec_t v;
        v.start  = 1'(st);
        v.f_done = 1'(fd);
        v.f_plot = 1'(fp);
        v.f_x    = X_W'(fx);
        v.f_y    = Y_W'(fy);
        v.f_col  = C_W'(fc);
        v.c_done = 1'(cd);
        v.c_plot = 1'(cp);
        v.c_x    = X_W'(cx);
        v.c_y    = Y_W'(cy);
        v.c_col  = C_W'(cc);
        v.expv   = {1'(efs), 1'(ecs), 1'(ed), 1'b0, 1'(ep), X_W'(ex), Y_W'(ey), C_W'(ec)};
        return v;
    endfunction

    task automatic drive(input vec_t v);
        start    = v.start;
        t_f_done = v.f_done;
        t_f_plot = v.f_plot;
        t_f_x    = v.f_x;
        t_f_y    = v.f_y;
        t_f_col  = v.f_col;
        t_c_done = v.c_done;
        t_c_plot = v.c_plot;
        t_c_x    = v.c_x;
        t_c_y    = v.c_y;
        t_c_col  = v.c_col;
    endtask

    task automatic clear_inputs();
        start = 1'b0;
        t_f_done = 1'b0; t_f_plot = 1'b0; t_f_x = '0; t_f_y = '0; t_f_col = '0;
        t_c_done = 1'b0; t_c_plot = 1'b0; t_c_x = '0; t_c_y = '0; t_c_col = '0;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        // Full-sequence scoreboard state
        logic           p_fs, p_cs, p_fp, p_cp, p_cd, p_cd_prev;
        logic [X_W-1:0] p_fx, p_cx, e_x;
        logic [Y_W-1:0] p_fy, p_cy, e_y;
        logic [C_W-1:0] p_fc, p_cc, e_c;
        logic           e_p;
        int             bad_cycles, fill_px, circ_px, cfall_cyc, done_cyc, n;
        bit             finished;

        // Rows: start fd fp fx fy fc | cd cp cx cy cc || f_start c_start done plot x y colour
        vecs.push_back(mk(0,0,0,0,0,0, 0,0, 0, 0,0, 0,0,0,0, 0, 0,0)); // idle
        vecs.push_back(mk(1,0,1,5,3,1, 0,0, 0, 0,0, 1,0,0,0, 0, 0,0)); // IDLE->FILL
        vecs.push_back(mk(1,0,1,5,3,1, 0,1,77, 9,7, 1,0,0,1, 5, 3,1)); // fill pixel, circle cross-talk
        vecs.push_back(mk(0,0,1,6,4,1, 1,1,77, 9,7, 1,0,0,1, 6, 4,1)); // start drop + stray c_done ignored
        vecs.push_back(mk(0,1,0,7,5,0, 0,1,77, 9,7, 0,0,0,0, 7, 5,0)); // f_done -> FILL_REL
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0,1,0,0,0,0, 0,1,77, 9,7, 0,0,0,0, 7, 5,0)); // f_done held
        vecs.push_back(mk(0,0,0,0,0,0, 0,1,77, 9,7, 0,1,0,0, 7, 5,0)); // -> DRAW
        vecs.push_back(mk(0,1,1,1,1,1, 0,1,20,30,2, 0,1,0,1,20,30,2)); // circle pixel, stray f_done
        vecs.push_back(mk(0,0,0,0,0,0, 1,0,21,31,2, 0,0,0,0,21,31,2)); // c_done -> DRAW_REL
        vecs.push_back(mk(0,0,0,0,0,0, 1,1,77, 9,7, 0,0,0,0,21,31,2)); // c_done held
        vecs.push_back(mk(0,0,0,0,0,0, 0,0, 0, 0,0, 0,0,1,0,21,31,2)); // -> DONE
        vecs.push_back(mk(0,0,0,0,0,0, 0,0, 0, 0,0, 0,0,0,0,21,31,2)); // start low -> IDLE
        vecs.push_back(mk(1,1,0,0,0,0, 0,0, 0, 0,0, 1,0,0,0,21,31,2)); // new start, f_done early
        vecs.push_back(mk(1,1,0,0,0,0, 0,0, 0, 0,0, 0,0,0,0, 0, 0,0)); // 1-cycle FILL
        vecs.push_back(mk(1,0,0,0,0,0, 0,0, 0, 0,0, 0,1,0,0, 0, 0,0)); // -> DRAW
        vecs.push_back(mk(1,0,0,0,0,0, 1,0, 0, 0,0, 0,0,0,0, 0, 0,0)); // 1-cycle DRAW
        vecs.push_back(mk(1,0,0,0,0,0, 0,0, 0, 0,0, 0,0,1,0, 0, 0,0)); // -> DONE
        vecs.push_back(mk(1,0,0,0,0,0, 0,0, 0, 0,0, 0,0,1,0, 0, 0,0)); // DONE holds while start
        vecs.push_back(mk(0,0,0,0,0,0, 0,0, 0, 0,0, 0,0,0,0, 0, 0,0)); // -> IDLE

        // ---- Reset state ----
        clear_inputs();
        #3;
        check("reset_outputs", 64'(outs()), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ---- Table-driven vectors ----
        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), 64'(outs()), 64'(vecs[i].expv));
        end

        // ---- Asynchronous reset in the middle of DRAW ----
        clear_inputs();
        start = 1'b1;
        @(posedge clk); #1;                 // FILL
        t_f_done = 1'b1;
        @(posedge clk); #1;                 // FILL_REL
        t_f_done = 1'b0;
        @(posedge clk); #1;                 // DRAW
        t_c_plot = 1'b1; t_c_x = 8'd50; t_c_y = 7'd60; t_c_col = 3'd5;
        @(posedge clk); #2;
        check("pre_reset_draw", 64'({c_start, vga_plot, vga_x}), 64'({1'b1, 1'b1, 8'd50}));
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 64'(outs()), 64'(0));
        check("async_reset_state", 64'(dut.r_state), 64'(IDLE));
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_idle", 64'(outs()), 64'(0));

        // ---- Full sequence with behavioural engines ----
        use_model  = 1'b1;
        start      = 1'b1;
        bad_cycles = 0;
        fill_px    = 0;
        circ_px    = 0;
        cfall_cyc  = -1;
        done_cyc   = -2;
        finished   = 1'b0;
        e_x = '0; e_y = '0; e_c = '0; e_p = 1'b0;
        p_cd = 1'b0;
        #5;
        p_fs = f_start; p_cs = c_start; p_fp = f_plot; p_cp = c_plot;
        p_fx = f_x; p_fy = f_y; p_fc = f_colour;
        p_cx = c_x; p_cy = c_y; p_cc = c_colour;
        p_cd_prev = p_cd; p_cd = c_done;
        for (int cyc = 0; cyc < 25000; cyc++) begin
            @(posedge clk); #1;
            if (p_fs) begin
                e_p = p_fp; e_x = p_fx; e_y = p_fy; e_c = p_fc;
            end else if (p_cs) begin
                e_p = p_cp; e_x = p_cx; e_y = p_cy; e_c = p_cc;
            end else begin
                e_p = 1'b0;
            end
            if ({vga_plot, vga_x, vga_y, vga_colour} !== {e_p, e_x, e_y, e_c})
                bad_cycles = bad_cycles + 1;
            if (vga_plot && vga_colour == 3'd0) fill_px = fill_px + 1;
            if (vga_plot && vga_colour == 3'd2) circ_px = circ_px + 1;
            if (p_cd_prev && !p_cd && cfall_cyc < 0) cfall_cyc = cyc;
            if (done) begin
                done_cyc = cyc;
                finished = 1'b1;
                break;
            end
            #5;
            p_fs = f_start; p_cs = c_start; p_fp = f_plot; p_cp = c_plot;
            p_fx = f_x; p_fy = f_y; p_fc = f_colour;
            p_cx = c_x; p_cy = c_y; p_cc = c_colour;
            p_cd_prev = p_cd; p_cd = c_done;
        end
        check("full_seq_completes", 64'(finished), 64'(1));
        check("stream_delay_mismatches", 64'(bad_cycles), 64'(0));
        check("fill_pixels", 64'(fill_px), 64'(SCREEN_W * SCREEN_H));
        check("circle_pixels", 64'(circ_px), 64'(40));
        check("done_after_cdone_fall", 64'(done_cyc), 64'(cfall_cyc));
        @(posedge clk); #1;
        check("done_held_with_start", 64'(done), 64'(1));
        start = 1'b0;
        @(posedge clk); #1;
        check("done_clears", 64'({done, f_start, c_start, vga_plot}), 64'(0));
        use_model = 1'b0;
        clear_inputs();
        @(posedge clk); #1;

`ifdef DRAW_SCHED_TIMEOUT_EN
        // ---- Phase timeout: circle engine never answers ----
        start = 1'b1;
        @(posedge clk); #1;                 // FILL
        t_f_done = 1'b1;
        @(posedge clk); #1;                 // FILL_REL
        t_f_done = 1'b0;
        @(posedge clk); #1;                 // DRAW
        check("timeout_err_clear_in_draw", 64'({c_start, err}), 64'({1'b1, 1'b0}));
        n = 0;
        while (c_start && n < 200) begin
            n = n + 1;
            @(posedge clk); #1;
        end
        check("timeout_draw_cycles", 64'(n), 64'(TIMEOUT_CYCLES));
        check("timeout_err_set", 64'({err, done}), 64'({1'b1, 1'b0}));
        @(posedge clk); #1;
        check("timeout_reaches_done", 64'({done, err}), 64'({1'b1, 1'b1}));
        start = 1'b0;
        @(posedge clk); #1;
        check("err_sticky_in_idle", 64'({done, err}), 64'({1'b0, 1'b1}));
        start = 1'b1;
        @(posedge clk); #1;
        check("err_clears_on_start", 64'({f_start, err}), 64'({1'b1, 1'b0}));
`else
        // ---- Without the timeout a phase waits indefinitely ----
        start = 1'b1;
        @(posedge clk); #1;
        t_f_done = 1'b1;
        @(posedge clk); #1;
        t_f_done = 1'b0;
        @(posedge clk); #1;                 // DRAW
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (c_start && !err) n = n + 1;
        end
        check("draw_waits_forever", 64'(n), 64'(100));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
